keypad_scan_fifo: RTL and testbench

//   Parametrised matrix-keypad scanner; successor to the fixed 4x4 scanner. Drives one

---
 rtl/keypad_scan_fifo_if.sv | 12 +
 rtl/keypad_scan_fifo.sv | 148 ++++++++++++++
 tb/tb_keypad_scan_fifo.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/keypad_scan_fifo_if.sv
// Event stream from the keypad scanner: head-of-FIFO key event with valid/ready handshake.
interface keypad_scan_fifo_if #(
  parameter int KEY_W = 4
);
  logic             evt_valid;
  logic             evt_ready;
  logic [KEY_W-1:0] evt_code;
  logic             evt_release;

  modport master (output evt_valid, output evt_code, output evt_release, input evt_ready);
  modport slave  (input evt_valid, input evt_code, input evt_release, output evt_ready);
endinterface

// File: rtl/keypad_scan_fifo.sv
// Matrix keypad scanner: column-at-a-time scan, whole-frame debounce, press/release
// events queued in a small FIFO drained through a valid/ready interface.
module keypad_scan_fifo #(
  parameter int CLK_KHZ        = 25000,
  parameter int NUM_ROWS       = 4,
  parameter int NUM_COLS       = 4,
  parameter int SETTLE_CYC     = 8,
  parameter int DEBOUNCE_SCANS = 3,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_ROWS-1:0]          row,
  output logic [NUM_COLS-1:0]          col,
  keypad_scan_fifo_if.master           evt,
  output logic [NUM_ROWS*NUM_COLS-1:0] key_down,
  output logic                         overflow,
  input  logic                         clr_ovf
);
  localparam int NUM_KEYS = NUM_ROWS * NUM_COLS;
  localparam int KEY_W    = $clog2(NUM_KEYS);
  localparam int DWELL_W  = $clog2(CLK_KHZ);
  localparam int CIDX_W   = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
  localparam int STAB_W   = $clog2(DEBOUNCE_SCANS + 1);
  localparam int PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W    = $clog2(FIFO_DEPTH + 1);

  typedef enum logic {S_SCAN, S_EMIT} state_t;

  state_t                state, state_next;
  logic [DWELL_W-1:0]    dwell;
  logic [CIDX_W-1:0]     col_idx;
  logic [NUM_KEYS-1:0]   raw, prev_raw;
  logic [STAB_W-1:0]     stable_cnt, stable_next;
  logic [KEY_W-1:0]      emit_k;
  logic                  frame_end, emit_last;
  logic                  push_req, push_rel;
  logic                  pop, full, do_push, drop;
  logic [KEY_W:0]        mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      count;

  always_ff @(posedge clk) begin
    if (rst) state <= S_SCAN;
    else     state <= state_next;
  end

  always_comb begin
    state_next  = state;
    push_req    = 1'b0;
    push_rel    = 1'b0;
    stable_next = stable_cnt;
    frame_end   = (state == S_SCAN) && (dwell == DWELL_W'(CLK_KHZ - 1)) &&
                  (col_idx == CIDX_W'(NUM_COLS - 1));
    emit_last   = (state == S_EMIT) && (emit_k == KEY_W'(NUM_KEYS - 1));
    if (raw != prev_raw)
      stable_next = STAB_W'(1);
    else if (stable_cnt < STAB_W'(DEBOUNCE_SCANS))
      stable_next = stable_cnt + STAB_W'(1);
    case (state)
      S_SCAN: begin
        if (frame_end && (stable_next >= STAB_W'(DEBOUNCE_SCANS)) && (raw != key_down))
          state_next = S_EMIT;
      end
      S_EMIT: begin
        push_req = raw[emit_k] != key_down[emit_k];
        push_rel = ~raw[emit_k];
        if (emit_last) state_next = S_SCAN;
      end
      default: state_next = S_SCAN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col        <= '1;
      dwell      <= '0;
      col_idx    <= '0;
      raw        <= '0;
      prev_raw   <= '0;
      stable_cnt <= '0;
      key_down   <= '0;
      emit_k     <= '0;
    end else begin
      case (state)
        S_SCAN: begin
          if (dwell == '0) col <= ~(NUM_COLS'(1) << col_idx);
          if (dwell == DWELL_W'(SETTLE_CYC)) begin
            for (int r = 0; r < NUM_ROWS; r++)
              raw[KEY_W'(int'(col_idx) * NUM_ROWS + r)] <= ~row[r];
          end
          if (dwell == DWELL_W'(CLK_KHZ - 1)) begin
            dwell <= '0;
            if (frame_end) begin
              stable_cnt <= stable_next;
              prev_raw   <= raw;
              col_idx    <= '0;
              emit_k     <= '0;
              if (state_next == S_EMIT) col <= '1;
            end else begin
              col_idx <= col_idx + CIDX_W'(1);
            end
          end else begin
            dwell <= dwell + DWELL_W'(1);
          end
        end
        S_EMIT: begin
          // key_down follows raw even when the event itself is dropped
          if (push_req) key_down[emit_k] <= raw[emit_k];
          emit_k <= emit_k + KEY_W'(1);
          if (emit_last) begin
            dwell   <= '0;
            col_idx <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign pop     = evt.evt_valid & evt.evt_ready;
  assign full    = count == CNT_W'(FIFO_DEPTH);
  assign do_push = push_req & (~full | pop);
  assign drop    = push_req & full & ~pop;

  assign evt.evt_valid   = count != '0;
  assign evt.evt_code    = evt.evt_valid ? mem[rd_ptr][KEY_W:1] : '0;
  assign evt.evt_release = evt.evt_valid & mem[rd_ptr][0];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= {emit_k, push_rel};
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      if (do_push && !pop)      count <= count + CNT_W'(1);
      else if (!do_push && pop) count <= count - CNT_W'(1);
      if (drop)         overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end
endmodule

// File: tb/tb_keypad_scan_fifo.sv
// Bench for keypad_scan_fifo: a frame-level keypad model with an event queue is checked
// against the DUT every cycle, alongside hand-computed literal checkpoints.
module tb_keypad_scan_fifo;
  logic        clk;
  logic        rst;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [15:0] key_down;
  logic        overflow;
  logic        clr_ovf;
  logic [15:0] pressed;

  int total = 0;
  int bad   = 0;

  keypad_scan_fifo_if #(.KEY_W(4)) bus ();

  keypad_scan_fifo #(
    .CLK_KHZ(20), .NUM_ROWS(4), .NUM_COLS(4), .SETTLE_CYC(2),
    .DEBOUNCE_SCANS(3), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .row(row), .col(col), .evt(bus),
    .key_down(key_down), .overflow(overflow), .clr_ovf(clr_ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Physical switch matrix: a closed key pulls its row low while its column is driven low
  always_comb begin
    row = '1;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (col[c] == 1'b0 && pressed[c*4+r]) row[r] = 1'b0;
  end

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Reference model: frame timeline (80 scan cycles, plus 16 emit cycles after an accepted change)
  bit          model_ok = 0;
  int          t;
  bit          m_emit;
  logic [15:0] m_raw, m_prev, m_kd;
  int          m_stable;
  logic [3:0]  m_col;
  logic [4:0]  q[$];
  bit          m_ovf;

  always @(posedge clk) begin : model_step
    bit         pop, push, dropped;
    int         k, c, d;
    logic [4:0] pe;
    if (rst) begin
      t = 0; m_emit = 0; m_raw = '0; m_prev = '0; m_kd = '0; m_stable = 0;
      m_col = 4'hF; q.delete(); m_ovf = 0; model_ok = 1;
    end else if (model_ok) begin
      pop = (q.size() > 0) && bus.evt_ready;
      push = 0; dropped = 0; pe = '0;
      if (m_emit) begin
        k = t - 80;
        if (m_raw[k] != m_kd[k]) begin
          push = 1;
          pe = {k[3:0], ~m_raw[k]};
          m_kd[k] = m_raw[k];
        end
        if (k == 15) begin t = 0; m_emit = 0; end
        else t++;
      end else begin
        c = t / 20;
        d = t % 20;
        if (d == 0) m_col = ~(4'b0001 << c);
        if (d == 2) for (int r = 0; r < 4; r++) m_raw[c*4+r] = pressed[c*4+r];
        if (t == 79) begin
          if (m_raw == m_prev) m_stable = (m_stable < 1000) ? m_stable + 1 : m_stable;
          else m_stable = 1;
          m_prev = m_raw;
          if (m_stable >= 3 && m_raw != m_kd) begin m_emit = 1; m_col = 4'hF; t = 80; end
          else t = 0;
        end else t++;
      end
      if (pop) void'(q.pop_front());
      if (push) begin
        if (q.size() < 4) q.push_back(pe);
        else dropped = 1;
      end
      if (dropped) m_ovf = 1;
      else if (clr_ovf) m_ovf = 0;
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      check_output("col", col, m_col);
      check_output("evt_valid", bus.evt_valid, q.size() > 0);
      if (q.size() > 0) begin
        check_output("evt_code", bus.evt_code, q[0][4:1]);
        check_output("evt_release", bus.evt_release, q[0][0]);
      end
      check_output("key_down", key_down, m_kd);
      check_output("overflow", overflow, m_ovf);
    end
  end

  logic [4:0] log_q[$];
  always @(posedge clk) begin
    if (!rst && bus.evt_valid && bus.evt_ready) log_q.push_back({bus.evt_code, bus.evt_release});
  end

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_stimulus(input logic [15:0] keys, input logic ready);
    pressed       = keys;
    bus.evt_ready = ready;
  endtask

  // Leaves the bench at the negedge just before edge 1 of the first frame
  task automatic do_reset(input logic ready);
    rst = 1'b1;
    clr_ovf = 1'b0;
    apply_stimulus(16'h0000, ready);
    wait_edges(2);
    rst = 1'b0;
    log_q.delete();
  endtask

  task automatic check_log(input string name, input int idx, input logic [4:0] expected);
    if (idx < log_q.size()) check_output(name, log_q[idx], expected);
    else check_output({name, "_present"}, 0, 1);
  endtask

  initial begin
    rst = 1'b1; clr_ovf = 1'b0; pressed = '0; bus.evt_ready = 1'b0;
    @(negedge clk);

    // 1: idle scan, column timing
    do_reset(1'b1);
    check_output("t1_reset_col", col, 4'hF);
    check_output("t1_reset_code", bus.evt_code, 0);
    check_output("t1_reset_rel", bus.evt_release, 0);
    wait_edges(1);  check_output("t1_col_e1", col, 4'hE);
    wait_edges(19); check_output("t1_col_e20", col, 4'hE);
    wait_edges(1);  check_output("t1_col_e21", col, 4'hD);
    wait_edges(20); check_output("t1_col_e41", col, 4'hB);
    wait_edges(20); check_output("t1_col_e61", col, 4'h7);
    wait_edges(19); check_output("t1_col_e80", col, 4'h7);
    wait_edges(1);  check_output("t1_col_e81", col, 4'hE);
    wait_edges(80);
    check_output("t1_valid", bus.evt_valid, 0);
    check_output("t1_key_down", key_down, 0);

    // 2: single key press held, then released
    do_reset(1'b0);
    apply_stimulus(16'h0200, 1'b0);
    wait_edges(249); check_output("t2_valid_e249", bus.evt_valid, 0);
    wait_edges(1);
    check_output("t2_valid_e250", bus.evt_valid, 1);
    check_output("t2_code", bus.evt_code, 9);
    check_output("t2_rel", bus.evt_release, 0);
    check_output("t2_key_down", key_down, 16'h0200);
    wait_edges(100);
    check_output("t2_held_code", bus.evt_code, 9);
    apply_stimulus(16'h0200, 1'b1);
    wait_edges(300);
    check_output("t2_press_count", log_q.size(), 1);
    check_log("t2_press_evt", 0, {4'd9, 1'b0});
    apply_stimulus(16'h0000, 1'b1);
    wait_edges(400);
    check_output("t2_release_count", log_q.size(), 2);
    check_log("t2_release_evt", 1, {4'd9, 1'b1});
    check_output("t2_key_up", key_down, 0);

    // 3: bounce shorter than the debounce window
    do_reset(1'b1);
    apply_stimulus(16'h0200, 1'b1);
    wait_edges(80);
    apply_stimulus(16'h0000, 1'b1);
    wait_edges(400);
    check_output("t3_1frame_events", log_q.size(), 0);
    check_output("t3_1frame_kd", key_down, 0);
    do_reset(1'b1);
    apply_stimulus(16'h0200, 1'b1);
    wait_edges(160);
    apply_stimulus(16'h0000, 1'b1);
    wait_edges(400);
    check_output("t3_2frame_events", log_q.size(), 0);
    check_output("t3_2frame_kd", key_down, 0);

    // 4: two keys accepted in the same frame; emit window length
    do_reset(1'b1);
    apply_stimulus(16'h8001, 1'b1);
    wait_edges(239); check_output("t4_col_e239", col, 4'h7);
    wait_edges(1);   check_output("t4_col_e240", col, 4'hF);
    wait_edges(16);  check_output("t4_col_e256", col, 4'hF);
    wait_edges(1);   check_output("t4_col_e257", col, 4'hE);
    check_output("t4_count", log_q.size(), 2);
    check_log("t4_first", 0, {4'd0, 1'b0});
    check_log("t4_second", 1, {4'd15, 1'b0});

    // 5: overflow with a stalled consumer
    do_reset(1'b0);
    apply_stimulus(16'h2852, 1'b0);
    wait_edges(260);
    check_output("t5_valid", bus.evt_valid, 1);
    check_output("t5_head", bus.evt_code, 1);
    check_output("t5_overflow", overflow, 1);
    check_output("t5_key_down", key_down, 16'h2852);
    apply_stimulus(16'h2852, 1'b1);
    wait_edges(6);
    check_output("t5_pops", log_q.size(), 4);
    check_log("t5_pop0", 0, {4'd1, 1'b0});
    check_log("t5_pop1", 1, {4'd4, 1'b0});
    check_log("t5_pop2", 2, {4'd6, 1'b0});
    check_log("t5_pop3", 3, {4'd11, 1'b0});
    check_output("t5_ovf_sticky", overflow, 1);
    clr_ovf = 1'b1;
    wait_edges(1);
    clr_ovf = 1'b0;
    check_output("t5_ovf_clr", overflow, 0);

    // 6: reset in the middle of EMIT and in the middle of a column dwell
    do_reset(1'b0);
    apply_stimulus(16'h0201, 1'b0);
    wait_edges(245);
    check_output("t6_pre_valid", bus.evt_valid, 1);
    check_output("t6_pre_kd", key_down, 16'h0001);
    rst = 1'b1;
    apply_stimulus(16'h0000, 1'b0);
    wait_edges(1);
    check_output("t6_col", col, 4'hF);
    check_output("t6_valid", bus.evt_valid, 0);
    check_output("t6_code", bus.evt_code, 0);
    check_output("t6_rel", bus.evt_release, 0);
    check_output("t6_kd", key_down, 0);
    check_output("t6_ovf", overflow, 0);
    rst = 1'b0;
    wait_edges(1);  check_output("t6_restart_col", col, 4'hE);
    wait_edges(29); check_output("t6_mid_col", col, 4'hD);
    rst = 1'b1;
    wait_edges(1);  check_output("t6_dwell_rst_col", col, 4'hF);
    rst = 1'b0;
    wait_edges(1);  check_output("t6_dwell_restart_col", col, 4'hE);
    wait_edges(100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
